// File: rtl/clock_phase_monitor.sv
// rtl/clock_phase_monitor.sv - phase-sequence checker and lock detector for the ClockBlk phase clocks
//
// Samples {c0,c1,c2} on inclk0. It recovers the phase index and declares lock after
// LOCK_CNT clean 4-sample periods. Any sequence break while locked is flagged and counted.
//
// Ports:
//   inclk0       in   source clock (also drives the phase generator)
//   rst_n        in   synchronous active-low reset
//   c0, c1, c2   in   phase clocks under test, synchronous to inclk0
//   gen_locked   in   generator lock flag; low holds the monitor in SEARCH
//   err_clr      in   synchronous clear of err_count
//   locked       out  monitor lock status
//   phase        out  recovered phase index of the last checked sample
//   phase_valid  out  phase is meaningful (mirrors locked)
//   err_pulse    out  one-cycle flag on a sequence break while locked
//   err_count    out  saturating break counter

module clock_phase_monitor #(
  parameter int LOCK_CNT = 8,
  parameter int ERR_W    = 8
) (
  input  logic             inclk0,
  input  logic             rst_n,
  input  logic             c0,
  input  logic             c1,
  input  logic             c2,
  input  logic             gen_locked,
  input  logic             err_clr,
  output logic             locked,
  output logic [1:0]       phase,
  output logic             phase_valid,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] LOCK_TGT = 8'(LOCK_CNT);

  state_t           state, state_nxt;
  logic [2:0]       s;
  logic [1:0]       exp_idx, exp_nxt;
  logic [7:0]       good, good_nxt, good_inc;
  logic [1:0]       phase_nxt;
  logic             err_nxt;
  logic [ERR_W-1:0] cnt_nxt;
  logic             dec_valid;
  logic [1:0]       dec;
  logic             match;

  // Legal phase patterns; everything else (000, 010, 101, 111) is invalid.
  always_comb begin
    dec_valid = 1'b1;
    dec       = 2'd0;
    case (s)
      3'b100:  dec = 2'd0;
      3'b110:  dec = 2'd1;
      3'b011:  dec = 2'd2;
      3'b001:  dec = 2'd3;
      default: dec_valid = 1'b0;
    endcase
  end

  assign match    = dec_valid && (dec == exp_idx);
  assign good_inc = good + 8'd1;

  always_comb begin
    state_nxt = state;
    exp_nxt   = exp_idx;
    good_nxt  = good;
    phase_nxt = phase;
    err_nxt   = 1'b0;
    if (!gen_locked) begin
      // Generator not locked: drop to SEARCH silently, never an error.
      state_nxt = SEARCH;
      good_nxt  = 8'd0;
    end else begin
      case (state)
        SEARCH: begin
          if (dec_valid) begin
            exp_nxt   = dec + 2'd1;
            good_nxt  = 8'd0;
            phase_nxt = dec;
            state_nxt = TRACK;
          end
        end
        TRACK: begin
          if (match) begin
            exp_nxt   = exp_idx + 2'd1;
            phase_nxt = dec;
            // A period counts as clean when its phase-3 sample lands in order.
            if (dec == 2'd3) begin
              good_nxt = good_inc;
              if (good_inc >= LOCK_TGT) state_nxt = LOCKED;
            end
          end else begin
            state_nxt = SEARCH;
            good_nxt  = 8'd0;
          end
        end
        LOCKED: begin
          if (match) begin
            exp_nxt   = exp_idx + 2'd1;
            phase_nxt = dec;
          end else begin
            // The offending sample is not reused for resync; SEARCH starts on the next one.
            err_nxt   = 1'b1;
            state_nxt = SEARCH;
            good_nxt  = 8'd0;
          end
        end
        default: begin
          state_nxt = SEARCH;
          good_nxt  = 8'd0;
        end
      endcase
    end
  end

  // A clear coinciding with a new error leaves that error counted.
  always_comb begin
    cnt_nxt = err_count;
    if (err_clr) begin
      cnt_nxt = err_nxt ? ERR_W'(1) : '0;
    end else if (err_nxt && (err_count != '1)) begin
      cnt_nxt = err_count + ERR_W'(1);
    end
  end

  always_ff @(posedge inclk0) begin
    if (!rst_n) begin
      s         <= 3'b000;
      state     <= SEARCH;
      exp_idx   <= 2'd0;
      good      <= 8'd0;
      phase     <= 2'd0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      s         <= {c0, c1, c2};
      state     <= state_nxt;
      exp_idx   <= exp_nxt;
      good      <= good_nxt;
      phase     <= phase_nxt;
      locked    <= (state_nxt == LOCKED);
      err_pulse <= err_nxt;
      err_count <= cnt_nxt;
    end
  end

  assign phase_valid = locked;

endmodule

// File: tb/tb_clock_phase_monitor.sv
// tb/tb_clock_phase_monitor.sv - self-checking bench for clock_phase_monitor (LOCK_CNT=2, ERR_W=2)

module tb_clock_phase_monitor;

  logic       inclk0 = 1'b0;
  logic       rst_n = 1'b0;
  logic       c0 = 1'b0, c1 = 1'b0, c2 = 1'b0;
  logic       gen_locked = 1'b1;
  logic       err_clr = 1'b0;
  logic       locked;
  logic [1:0] phase;
  logic       phase_valid;
  logic       err_pulse;
  logic [1:0] err_count;

  clock_phase_monitor #(.LOCK_CNT(2), .ERR_W(2)) dut (
    .inclk0      (inclk0),
    .rst_n       (rst_n),
    .c0          (c0),
    .c1          (c1),
    .c2          (c2),
    .gen_locked  (gen_locked),
    .err_clr     (err_clr),
    .locked      (locked),
    .phase       (phase),
    .phase_valid (phase_valid),
    .err_pulse   (err_pulse),
    .err_count   (err_count)
  );

  always #5 inclk0 = ~inclk0;

  // One record per sample. gl/clr are applied on the edge that evaluates this
  // sample, so each record fully describes one FSM decision.
  typedef struct {
    logic [2:0] c;
    bit         gl;
    bit         clr;
    bit         chk;
    bit         lk;
    logic [1:0] ph;
    bit         pl;
    int         cnt;
    string      nm;
  } vec_t;

  vec_t       q[$];
  vec_t       tbl[12];
  logic [2:0] pat[4];
  int         total = 0;
  int         bad = 0;
  bit         gl_d = 1'b1;
  bit         clr_d = 1'b0;
  int         sidx = 0;

  task automatic check(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] c, input bit gl, input bit clr,
                              input bit lk, input logic [1:0] ph, input bit pl, input int cnt);
    vec_t v;
    v.c = c; v.gl = gl; v.clr = clr; v.chk = 1'b1;
    v.lk = lk; v.ph = ph; v.pl = pl; v.cnt = cnt; v.nm = "";
    return v;
  endfunction

  task automatic compare(input vec_t v);
    if (v.chk) begin
      check({v.nm, " locked"}, int'(locked), int'(v.lk));
      check({v.nm, " phase_valid"}, int'(phase_valid), int'(v.lk));
      check({v.nm, " err_pulse"}, int'(err_pulse), int'(v.pl));
      check({v.nm, " err_count"}, int'(err_count), v.cnt);
      if (v.lk) check({v.nm, " phase"}, int'(phase), int'(v.ph));
    end
  endtask

  // Drive a sample before the edge; its effect appears one edge later, so the
  // previous record is compared after each edge.
  task automatic apply(input vec_t v);
    v.nm = $sformatf("s%0d", sidx);
    sidx++;
    @(negedge inclk0);
    rst_n = 1'b1;
    {c0, c1, c2} = v.c;
    gen_locked = gl_d;
    err_clr = clr_d;
    gl_d = v.gl;
    clr_d = v.clr;
    q.push_back(v);
    @(posedge inclk0);
    #1;
    if (q.size() == 2) compare(q.pop_front());
  endtask

  task automatic st(input logic [2:0] c, input bit gl, input bit clr,
                    input bit lk, input logic [1:0] ph, input bit pl, input int cnt);
    apply(mk(c, gl, clr, lk, ph, pl, cnt));
  endtask

  // Two clean periods starting from 100 while in SEARCH: locks on the last 001.
  task automatic relock(input int cnt);
    for (int i = 0; i < 8; i++) st(pat[i % 4], 1'b1, 1'b0, (i == 7), 2'd3, 1'b0, cnt);
  endtask

  task automatic flush();
    vec_t v;
    v = mk(3'b110, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 0);
    v.chk = 1'b0;
    apply(v);
  endtask

  task automatic do_reset(input string tag);
    @(negedge inclk0);
    rst_n = 1'b0;
    {c0, c1, c2} = 3'b000;
    gen_locked = 1'b1;
    err_clr = 1'b0;
    gl_d = 1'b1;
    clr_d = 1'b0;
    q.delete();
    sidx = 0;
    @(posedge inclk0);
    #1;
    check({tag, " locked"}, int'(locked), 0);
    check({tag, " phase_valid"}, int'(phase_valid), 0);
    check({tag, " phase"}, int'(phase), 0);
    check({tag, " err_pulse"}, int'(err_pulse), 0);
    check({tag, " err_count"}, int'(err_count), 0);
  endtask

  task automatic run_table();
    for (int i = 0; i < 12; i++) apply(tbl[i]);
  endtask

  initial begin
    pat[0] = 3'b100; pat[1] = 3'b110; pat[2] = 3'b011; pat[3] = 3'b001;
    // Clean lock: locked low through sample 6, high from sample 7, then phase 0..3.
    for (int i = 0; i < 12; i++)
      tbl[i] = mk(pat[i % 4], 1'b1, 1'b0, (i >= 7), 2'(i % 4), 1'b0, 0);

    do_reset("reset0");
    run_table();

    // Break with 111 while locked, then relock after two periods.
    st(3'b111, 1, 0, 0, 2'd0, 1, 1);
    relock(1);

    // Skipped phase 110 -> 001 while locked; resync must start after the 001.
    st(3'b100, 1, 0, 1, 2'd0, 0, 1);
    st(3'b110, 1, 0, 1, 2'd1, 0, 1);
    st(3'b001, 1, 0, 0, 2'd0, 1, 2);
    st(3'b011, 1, 0, 0, 2'd0, 0, 2);
    st(3'b001, 1, 0, 0, 2'd0, 0, 2);
    st(3'b100, 1, 0, 0, 2'd0, 0, 2);
    st(3'b110, 1, 0, 0, 2'd0, 0, 2);
    st(3'b011, 1, 0, 0, 2'd0, 0, 2);
    st(3'b001, 1, 0, 1, 2'd3, 0, 2);

    // gen_locked low for 3 cycles: silent drop, then relock.
    st(3'b100, 1, 0, 1, 2'd0, 0, 2);
    st(3'b110, 0, 0, 0, 2'd0, 0, 2);
    st(3'b011, 0, 0, 0, 2'd0, 0, 2);
    st(3'b001, 0, 0, 0, 2'd0, 0, 2);
    relock(2);

    // Mismatch in TRACK: 100,110,100 raises no error.
    st(3'b100, 0, 0, 0, 2'd0, 0, 2);
    st(3'b100, 1, 0, 0, 2'd0, 0, 2);
    st(3'b110, 1, 0, 0, 2'd0, 0, 2);
    st(3'b100, 1, 0, 0, 2'd0, 0, 2);
    st(3'b110, 1, 0, 0, 2'd0, 0, 2);
    st(3'b011, 1, 0, 0, 2'd0, 0, 2);
    st(3'b001, 1, 0, 0, 2'd0, 0, 2);
    st(3'b100, 1, 0, 0, 2'd0, 0, 2);
    st(3'b110, 1, 0, 0, 2'd0, 0, 2);
    st(3'b011, 1, 0, 0, 2'd0, 0, 2);
    st(3'b001, 1, 0, 1, 2'd3, 0, 2);

    // Counter corners: third and fourth breaks saturate at 3.
    st(3'b111, 1, 0, 0, 2'd0, 1, 3);
    relock(3);
    st(3'b111, 1, 0, 0, 2'd0, 1, 3);
    relock(3);
    // Clear together with a fifth break leaves the count at 1.
    st(3'b111, 1, 1, 0, 2'd0, 1, 1);
    relock(1);
    // Clear alone while locked, then one more break.
    st(3'b100, 1, 1, 1, 2'd0, 0, 0);
    st(3'b111, 1, 0, 0, 2'd0, 1, 1);
    relock(1);
    st(3'b100, 1, 0, 1, 2'd0, 0, 1);
    flush();

    // Reset mid-lock clears everything, then a fresh clean lock.
    do_reset("reset_mid");
    run_table();
    flush();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
